// File: rtl/ep_buf_exerciser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ep_buf_exerciser_pkg
// Description : Shared FSM state encoding and pattern-mode constants for the
//               endpoint buffer RAM self-test engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ep_buf_exerciser_pkg;

    // Engine sequencer states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

    // Test pattern selection
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_ADDR  = 2'd0;
    localparam mode_t MODE_INV   = 2'd1;
    localparam mode_t MODE_LFSR  = 2'd2;
    localparam mode_t MODE_CONST = 2'd3;

endpackage : ep_buf_exerciser_pkg
`default_nettype wire

// File: rtl/ep_buf_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : ep_buf_pattern_gen
// Description : Produces the test word for the current address. Holds a
//               Galois LFSR that is restarted by init and advanced by step.
//               The address arrives already sized to the data width.
// Revision    : 1.0 - initial release
// ============================================================================
module ep_buf_pattern_gen
    import ep_buf_exerciser_pkg::*;
#(
    parameter int             DW   = 8,
    parameter logic [DW-1:0]  SEED = DW'(8'hA5),
    parameter logic [DW-1:0]  POLY = DW'(8'hB8)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] addr,
    input  logic          init,
    input  logic          step,
    output logic [DW-1:0] pattern
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [DW-1:0] LFSR_INIT = (SEED == '0) ? DW'(1) : SEED;

    logic [DW-1:0] lfsr;
    logic [DW-1:0] lfsr_next;

    // Galois shift: drop the LSB and fold it back through the taps
    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);
    end

    // LFSR register; init takes priority so the read pass restarts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_INIT;
        end else if (init) begin
            lfsr <= LFSR_INIT;
        end else if (step) begin
            lfsr <= lfsr_next;
        end
    end

    // Select the word for the current mode
    always_comb begin
        pattern = addr;
        case (mode)
            MODE_ADDR:  pattern = addr;
            MODE_INV:   pattern = ~addr;
            MODE_LFSR:  pattern = lfsr;
            MODE_CONST: pattern = SEED;
            default:    pattern = addr;
        endcase
    end

endmodule : ep_buf_pattern_gen
`default_nettype wire

// File: rtl/ep_buf_exerciser.sv
`default_nettype none
// ============================================================================
// Module      : ep_buf_exerciser
// Description : Endpoint buffer RAM self-test engine. Writes a pattern over
//               len words, reads them back, and counts/locates mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module ep_buf_exerciser
    import ep_buf_exerciser_pkg::*;
#(
    parameter int             AW   = 11,
    parameter int             DW   = 8,
    parameter int             ECW  = 16,
    parameter logic [DW-1:0]  SEED = DW'(8'hA5),
    parameter logic [DW-1:0]  POLY = DW'(8'hB8)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [AW:0]    len,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [ECW-1:0] err_cnt,
    output logic [AW-1:0]  first_err_addr,
    output logic [AW-1:0]  ram_waddr,
    output logic [DW-1:0]  ram_wdata,
    output logic           ram_we,
    output logic [AW-1:0]  ram_raddr,
    output logic           ram_re,
    input  logic [DW-1:0]  ram_rdata
);

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     mode_q;
    logic [AW:0]    len_q;
    logic [AW-1:0]  addr_cnt;
    logic           last_word;
    logic           pass_q;
    logic [DW-1:0]  pattern;
    logic           gen_init;
    logic           gen_step;
    logic           cmp_v;
    logic [DW-1:0]  exp_q;
    logic [AW-1:0]  cmp_addr_q;

    // Last word of a pass; len_q already holds 2^AW for a len of 0
    assign last_word = ({1'b0, addr_cnt} == (len_q - (AW+1)'(1)));

    // Generator restarts at launch and again between the write and read passes
    assign gen_init = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && last_word);
    assign gen_step = (state == ST_WRITE) || (state == ST_READ);

    ep_buf_pattern_gen #(
        .DW   (DW),
        .SEED (SEED),
        .POLY (POLY)
    ) u_pattern_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode_q),
        .addr    (DW'(addr_cnt)),
        .init    (gen_init),
        .step    (gen_step),
        .pattern (pattern)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)     state_nxt = ST_WRITE;
            ST_WRITE: if (last_word) state_nxt = ST_READ;
            ST_READ:  if (last_word) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; RAM buses held at zero when idle
    always_comb begin
        busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
        done      = (state == ST_FIN);
        ram_we    = (state == ST_WRITE);
        ram_re    = (state == ST_READ);
        ram_waddr = (state == ST_WRITE) ? addr_cnt : '0;
        ram_wdata = (state == ST_WRITE) ? pattern  : '0;
        ram_raddr = (state == ST_READ)  ? addr_cnt : '0;
        pass      = (state == ST_FIN) ? (err_cnt == '0) : pass_q;
    end

    // Expected word and address delayed one stage to meet ram_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_v      <= 1'b0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
        end else begin
            cmp_v      <= (state == ST_READ);
            exp_q      <= pattern;
            cmp_addr_q <= addr_cnt;
        end
    end

    // Run setup, address counter, mismatch counting and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q         <= MODE_ADDR;
            len_q          <= '0;
            addr_cnt       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass_q         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q         <= mode;
                        len_q          <= (len == '0) ? {1'b1, {AW{1'b0}}} : len;
                        addr_cnt       <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass_q         <= 1'b0;
                    end
                end
                ST_WRITE, ST_READ: begin
                    addr_cnt <= last_word ? '0 : addr_cnt + AW'(1);
                end
                ST_FIN: begin
                    pass_q <= (err_cnt == '0);
                end
                default: ;
            endcase

            // A zero count means no mismatch yet, so this is the first one
            if (cmp_v && (ram_rdata != exp_q)) begin
                if (err_cnt != {ECW{1'b1}}) begin
                    err_cnt <= err_cnt + ECW'(1);
                end
                if (err_cnt == '0) begin
                    first_err_addr <= cmp_addr_q;
                end
            end
        end
    end

endmodule : ep_buf_exerciser
`default_nettype wire

// File: tb/tb_ep_buf_exerciser.sv
`default_nettype none
// ============================================================================
// Module      : tb_ep_buf_exerciser
// Description : Directed bench for ep_buf_exerciser with a behavioural RAM
//               that can inject read faults, and write/result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ep_buf_exerciser;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int ECW = 2;

    // LFSR sequence for seed 0xA5, taps 0xB8, worked out by hand
    localparam logic [7:0] LFSR_TAB [8] = '{8'hA5, 8'hEA, 8'h75, 8'h82,
                                            8'h41, 8'h98, 8'h4C, 8'h26};

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] err;
        logic [3:0] first;
        logic       pass;
        int         done_cyc;
    } res_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [1:0]     mode;
    logic [AW:0]    len;
    logic           busy;
    logic           done;
    logic           pass;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  first_err_addr;
    logic [AW-1:0]  ram_waddr;
    logic [DW-1:0]  ram_wdata;
    logic           ram_we;
    logic [AW-1:0]  ram_raddr;
    logic           ram_re;
    logic [DW-1:0]  ram_rdata;

    logic [7:0] mem [16];
    int         fault = 0;
    int         checks = 0;
    int         failures = 0;
    wr_t        wq[$];
    res_t       rq[$];

    ep_buf_exerciser #(
        .AW  (AW),
        .DW  (DW),
        .ECW (ECW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_raddr      (ram_raddr),
        .ram_re         (ram_re),
        .ram_rdata      (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, optional read corruption
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) begin
            case (fault)
                1:       ram_rdata <= mem[ram_raddr] ^ ((ram_raddr == 4'd5) ? 8'h01 : 8'h00);
                2:       ram_rdata <= 8'h00;
                default: ram_rdata <= mem[ram_raddr];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: expectations are queued up front, then checked as the DUT acts
    task automatic run(input logic [1:0] m, input logic [4:0] l, input int f,
                       input int ra, input int rb, input int rc, input int abort_at,
                       input logic [1:0] e_err, input logic [3:0] e_first, input logic e_pass);
        int   n;
        int   cyc;
        int   ndone;
        wr_t  w;
        res_t r;
        n     = (l == 5'd0) ? 16 : int'(l);
        fault = f;
        wq.delete();
        rq.delete();
        for (int i = 0; i < n; i++) begin
            w.addr = 4'(i);
            case (m)
                2'd0:    w.data = 8'(i);
                2'd1:    w.data = ~8'(i);
                2'd2:    w.data = LFSR_TAB[i];
                default: w.data = 8'hA5;
            endcase
            wq.push_back(w);
        end
        r.err = e_err; r.first = e_first; r.pass = e_pass; r.done_cyc = 2 * n + 3;
        rq.push_back(r);

        @(negedge clk);
        mode = m; len = l; start = 1'b1;
        cyc = 1; ndone = 0;
        while (cyc < 2 * n + 6) begin
            @(negedge clk);
            cyc++;
            start = (cyc == ra) || (cyc == rb) || (cyc == rc);
            if (cyc == 4) begin
                mode = ~m;
                len  = 5'd2;
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_we", 32'(ram_we), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_err", 32'(err_cnt), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("post_abort_done", 32'(done), 32'd0);
                    chk("post_abort_busy", 32'(busy), 32'd0);
                end
                wq.delete();
                rq.delete();
                return;
            end
            if (cyc == 2) chk("busy_rise", 32'(busy), 32'd1);
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("extra_write", 32'(ram_we), 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("waddr", 32'(ram_waddr), 32'(w.addr));
                    chk("wdata", 32'(ram_wdata), 32'(w.data));
                end
            end
            if (done) begin
                ndone++;
                if (ndone == 1 && rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(r.done_cyc));
                    chk("err_cnt", 32'(err_cnt), 32'(r.err));
                    chk("first_err_addr", 32'(first_err_addr), 32'(r.first));
                    chk("pass_at_done", 32'(pass), 32'(r.pass));
                end
            end
        end
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("writes_left", 32'(wq.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("pass_held", 32'(pass), 32'(e_pass));
        chk("err_held", 32'(err_cnt), 32'(e_err));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; len = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_first", 32'(first_err_addr), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_re", 32'(ram_re), 32'd0);
        chk("rst_waddr", 32'(ram_waddr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_raddr", 32'(ram_raddr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Address pattern over the full 16-word RAM, clean readback
        run(2'd0, 5'd16, 0, 0, 0, 0, 0, 2'd0, 4'd0, 1'b1);
        // LFSR pattern with bit0 of address 5 corrupted on read
        run(2'd2, 5'd8, 1, 0, 0, 0, 0, 2'd1, 4'd5, 1'b0);
        // Inverted address with len=0 meaning the whole 2^AW span
        run(2'd1, 5'd0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 1'b1);
        // Constant fill against a RAM reading all zeros: counter saturates
        run(2'd3, 5'd10, 2, 0, 0, 0, 0, 2'd3, 4'd0, 1'b0);
        // Extra starts while busy and during FIN, inputs changed mid-run
        run(2'd0, 5'd8, 0, 3, 10, 19, 0, 2'd0, 4'd0, 1'b1);
        // Reset mid-run, then a normal run must still complete
        run(2'd0, 5'd8, 0, 0, 0, 0, 6, 2'd0, 4'd0, 1'b1);
        run(2'd1, 5'd8, 0, 0, 0, 0, 0, 2'd0, 4'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ep_buf_exerciser
`default_nettype wire
